// File: rtl/fifo_drain_pkg.sv
// Shared constants and helpers for the FIFO read-side drain block.
package fifo_drain_pkg;

  localparam int DEF_WIDTH  = 45;
  localparam int FIFO_DEPTH = 32;
  localparam int DEF_CNTW   = 16;

  typedef logic [1:0] occ_t;

  // A new pop is allowed only if every word already owed to the buffer still fits after this cycle's transfer.
  function automatic logic rd_allowed(occ_t occ, logic inflight, logic xfer);
    logic [2:0] pending;
    pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};
    return pending < 3'd2;
  endfunction

endpackage

// File: rtl/fifo_drain_if.sv
// FIFO read port plus downstream push/stop port of the drain block.
interface fifo_drain_if
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_rd;
  logic             pushout;
  logic             stopin;
  logic [WIDTH-1:0] dout;
  logic [CNTW-1:0]  delivered;

  modport master (
    input  fifo_empty, fifo_dout, stopin,
    output fifo_rd, pushout, dout, delivered
  );

  modport slave (
    output fifo_empty, fifo_dout, stopin,
    input  fifo_rd, pushout, dout, delivered
  );
endinterface

// File: rtl/fifo_drain_skid_buf2.sv
// Two-entry register buffer; entry 0 is always the head and shifts forward on pop.
module skid_buf2
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output occ_t             occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= din;
          else             ent1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // pop only happens with occ != 0, so occ is 1 or 2 here
          if (occ == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = ent0;

endmodule

// File: rtl/fifo_drain.sv
// Pops the FIFO, absorbs its one-cycle read latency in a skid buffer and
// presents words downstream on a registered push/stop port at full rate.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW
) (
  input  logic          clk,
  input  logic          reset,
  fifo_drain_if.master  bus
);

  occ_t             occ;
  logic             inflight;
  logic             xfer;
  logic             rd_req;
  logic [WIDTH-1:0] head;
  logic [CNTW-1:0]  delivered;

  assign xfer   = (occ != 2'd0) && !bus.stopin;
  assign rd_req = !bus.fifo_empty && rd_allowed(occ, inflight, xfer);

  // Gate with reset so no pop escapes while state is held cleared.
  assign bus.fifo_rd = rd_req && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight  <= 1'b0;
      delivered <= '0;
    end else begin
      inflight <= bus.fifo_rd;
      if (xfer) delivered <= delivered + 1'b1;
    end
  end

  skid_buf2 #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .din   (bus.fifo_dout),
    .pop   (xfer),
    .occ   (occ),
    .head  (head)
  );

  assign bus.pushout   = (occ != 2'd0);
  assign bus.dout      = head;
  assign bus.delivered = delivered;

endmodule

// File: tb/tb_fifo_drain.sv
// Randomized bench for fifo_drain against a queue-based model of the FIFO and skid buffer.
module tb_fifo_drain;
  import fifo_drain_pkg::*;

  logic clk;
  logic reset;

  fifo_drain_if #(.WIDTH(45), .CNTW(16)) bus ();
  fifo_drain_if #(.WIDTH(45), .CNTW(4))  bus4 ();

  fifo_drain #(.WIDTH(45), .CNTW(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
  fifo_drain #(.WIDTH(45), .CNTW(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

  assign bus4.fifo_empty = bus.fifo_empty;
  assign bus4.fifo_dout  = bus.fifo_dout;
  assign bus4.stopin     = bus.stopin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [44:0] src[$];
  logic [44:0] q[$];
  bit          m_inflight = 0;
  int unsigned m_cnt = 0;
  int          push_cycles = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at posedge+1; checks outputs at the falling edge and advances the model at the next rising edge.
  task automatic step(input bit stop, input bit hold);
    bit exp_push, xfer, exp_rd, rd_act;
    bus.stopin     = stop;
    bus.fifo_empty = hold || (src.size() == 0);
    #4;
    exp_push = (q.size() != 0);
    xfer     = exp_push && !stop;
    exp_rd   = !bus.fifo_empty && ((q.size() + int'(m_inflight) - int'(xfer)) < 2);
    check_eq("fifo_rd",    bus.fifo_rd,    exp_rd);
    check_eq("fifo_rd4",   bus4.fifo_rd,   exp_rd);
    check_eq("pushout",    bus.pushout,    exp_push);
    check_eq("pushout4",   bus4.pushout,   exp_push);
    if (exp_push) check_eq("dout", bus.dout, q[0]);
    check_eq("delivered",  bus.delivered,  m_cnt & 32'hFFFF);
    check_eq("delivered4", bus4.delivered, m_cnt & 32'hF);
    if (bus.pushout) push_cycles++;
    rd_act = bus.fifo_rd;
    @(posedge clk);
    #1;
    if (xfer) begin
      void'(q.pop_front());
      m_cnt++;
    end
    if (m_inflight) q.push_back(bus.fifo_dout);
    m_inflight = exp_rd;
    if (rd_act && src.size() > 0) bus.fifo_dout = src.pop_front();
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (src.size() == 0 && q.size() == 0 && !m_inflight) done = 1;
      else step(1'b0, 1'b0);
    end
    check_eq("drain_done", done, 1);
  endtask

  // Entered at posedge+1; async assert, immediate checks, release before the next edge.
  task automatic do_reset();
    bus.fifo_empty = 1'b1;
    reset = 1'b0;
    #1;
    check_eq("rst_pushout",    bus.pushout,    0);
    check_eq("rst_fifo_rd",    bus.fifo_rd,    0);
    check_eq("rst_delivered",  bus.delivered,  0);
    check_eq("rst_delivered4", bus4.delivered, 0);
    q.delete();
    m_inflight = 0;
    m_cnt = 0;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    bit reached;
    reset          = 1'b0;
    bus.fifo_empty = 1'b0;
    bus.stopin     = 1'b0;
    bus.fifo_dout  = '0;

    @(posedge clk);
    #2;
    check_eq("reset_fifo_rd",   bus.fifo_rd,   0);
    check_eq("reset_pushout",   bus.pushout,   0);
    check_eq("reset_dout",      bus.dout,      0);
    check_eq("reset_delivered", bus.delivered, 0);
    bus.fifo_empty = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    src.push_back(45'h1_2345_6789);
    drain();
    check_eq("single_delivered", bus.delivered, 1);

    base = m_cnt;
    push_cycles = 0;
    for (int i = 0; i < 32; i++) src.push_back(45'(i));
    drain();
    check_eq("stream_push_cycles", push_cycles, 32);
    check_eq("stream_delivered", m_cnt - base, 32);

    base = m_cnt;
    for (int i = 0; i < 10; i++) src.push_back(45'h100 + 45'(i));
    for (int i = 0; i < 12; i++) step(i >= 4 && i < 9, 1'b0);
    drain();
    check_eq("bp_delivered", m_cnt - base, 10);

    base = m_cnt;
    for (int i = 1; i <= 3; i++) src.push_back(45'h200 + 45'(i));
    for (int i = 0; i < 14; i++) step(i[0], 1'b0);
    drain();
    check_eq("empty_delivered", m_cnt - base, 3);

    for (int i = 0; i < 600; i++) begin
      if (src.size() < FIFO_DEPTH && $urandom_range(99) < 60)
        src.push_back({13'($urandom), 32'($urandom)});
      step($urandom_range(99) < 30, $urandom_range(99) < 20);
    end
    drain();

    do_reset();
    for (int i = 0; i < 17; i++) src.push_back(45'h300 + 45'(i));
    drain();
    check_eq("wrap_delivered4", bus4.delivered, 1);
    check_eq("wrap_delivered",  bus.delivered,  17);

    for (int i = 0; i < 5; i++) src.push_back(45'h400 + 45'(i));
    reached = 0;
    for (int i = 0; i < 10 && !reached; i++) begin
      if (q.size() == 2) reached = 1;
      else step(1'b1, 1'b0);
    end
    check_eq("occ2_reached", reached, 1);
    do_reset();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_drain.md
# fifo_drain

Reader-side companion for the 45-bit, 32-deep push/stop FIFO. Pops words from the FIFO read port, absorbs the FIFO's one-cycle registered read latency in a 2-entry skid buffer, and presents them downstream on a registered push/stop interface at full throughput. Sits directly after the FIFO in the datapath; it is the consumer that drives the FIFO's read strobe.

## Interface
- `WIDTH`, 45, data word width.
- `CNTW`, 16, width of the delivered-word counter.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `fifo_empty`  in  1  FIFO has no readable word.
- `fifo_dout`  in  WIDTH  FIFO read data; valid the cycle after `fifo_rd` was sampled high.
- `fifo_rd`  out  1  pop request; one word per cycle asserted.
- `pushout`  out  1  `dout` holds a valid word.
- `stopin`  in  1  downstream cannot accept this cycle.
- `dout`  out  WIDTH  output word.
- `delivered`  out  CNTW  count of words transferred downstream, wraps modulo 2^CNTW.

## Operation
- Downstream transfer: a cycle with `pushout`=1 and `stopin`=0. Only then may `dout` change to the next word.
- While `pushout`=1 and `stopin`=1, `dout` and `pushout` hold stable (no drop, no reorder).
- Skid buffer: 2 entries, head entry drives `dout`. `occ` in 0..2; `inflight` = `fifo_rd` registered (0/1).
- `fifo_rd` = !`fifo_empty` && (`occ` + `inflight` − (transfer this cycle ? 1 : 0)) < 2. Combinational from registered state, `fifo_empty`, `stopin`.
- Capture: when `inflight`=1, `fifo_dout` is written to the tail entry that cycle. Capture and transfer in the same cycle: `occ` unchanged, head advances.
- `pushout` = (`occ` != 0), registered-state only; `dout` = head entry register.
- `delivered` increments by 1 on each transfer; wraps from 2^CNTW−1 to 0.
- Never pops an empty FIFO; never overflows skid buffer (occ+inflight ≤ 2 invariant).

## Timing
- Reset (`reset`=0, async): `occ`=0, `inflight`=0, `pushout`=0, `dout`=0, `delivered`=0, `fifo_rd`=0 (forced while reset asserted). Release takes effect at next rising edge.
- Latency: `fifo_empty` falls in cycle N with buffer empty → `fifo_rd`=1 in N → data captured end of N+1 → `pushout`=1 in N+2.
- Throughput: 1 word/cycle sustained while `stopin`=0 and FIFO non-empty.
- `stopin` rising with a read in flight: in-flight word lands in second entry; `fifo_rd` deasserts same cycle when occ+inflight reaches 2.
- `stopin` falling with occ=2: head transfers that cycle, `fifo_rd` may re-assert that cycle; no bubble beyond the read latency.
- Reset asserted mid-stream: all buffered and in-flight words discarded; FIFO pop in flight is lost by design.

## Structure
- Shared package: `WIDTH` default (45), FIFO depth constant (32), `CNTW` default.
- One natural sub-module: `skid_buf2` (2-entry register buffer with occupancy, push/pop, head output). Top-level holds read-issue logic, `inflight` flag, counter.

## Test plan
- Reset: hold `reset`=0 with `fifo_empty`=0, `stopin`=0 → `fifo_rd`=0, `pushout`=0, `dout`=0, `delivered`=0.
- Single word: FIFO supplies 45'h1_2345_6789 → `fifo_rd` one cycle, `pushout`=1 exactly 2 cycles after, `dout`=45'h1_2345_6789, `delivered`=1.
- Streaming: 32 words 0..31, `stopin`=0 → 32 consecutive `pushout` cycles, in order, `delivered`=32.
- Backpressure: stream 10 words, `stopin`=1 for 5 cycles mid-stream → `dout` stable during stall, no more than 2 pops beyond last transfer, all 10 delivered in order.
- Empty boundary: FIFO goes empty after word 3 while `stopin` toggles every cycle → `fifo_rd` never asserted with `fifo_empty`=1, words 1-3 delivered exactly once.
- Reset mid-operation + wrap: `CNTW`=4, deliver 17 words → `delivered`=1; assert `reset` with occ=2 → `pushout`=0 immediately, `delivered`=0.
